fa_32b_sched: RTL

- Round-robin scheduler that shares a single fa_32b ripple-carry adder instance among NUM_REQ requesters.
- Each requester posts one addition (a, b, c_in). The scheduler grants one requester, latches its operands into the adder, registers the sum, and returns a one-cycle done pulse to that requester.
- Sits between the network's accumulate/bias stages and the one shared 32-bit adder, so that per-stage adders are not duplicated.

---
 rtl/fa_32b_sched.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/fa_32b_sched.sv
// ---------------------------------------------------------------------------
// fa_32b_sched
//   Round-robin scheduler that shares one 32-bit ripple-carry adder (fa_32b)
//   between NUM_REQ requesters. A winner's operands are latched in IDLE, the
//   adder result is registered in EXEC, and the winner gets a one-cycle done
//   pulse in RESP.
//
// Optional feature: define FA_32B_SCHED_OVF_EN to add the registered signed
//   overflow output ovf.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   req        : per-requester request level            [NUM_REQ]
//   req_a      : operand A, requester i at [32*i+31:32*i] [NUM_REQ*32]
//   req_b      : operand B, same packing as req_a        [NUM_REQ*32]
//   req_cin    : per-requester carry-in                   [NUM_REQ]
//   grant      : one-hot owner of the in-flight operation [NUM_REQ]
//   grant_idx  : binary index of current/last owner       [IDX_W]
//   done       : one-hot, one-cycle result-valid pulse     [NUM_REQ]
//   sum        : registered sum of last completed op       [32]
//   c_out      : registered carry-out of last completed op
//   busy       : high whenever the FSM is not idle
//   ovf        : (FA_32B_SCHED_OVF_EN only) registered signed overflow
// ---------------------------------------------------------------------------

// 32-bit ripple-carry adder. The carry is rippled through a loop variable so
// the chain stays a plain combinational cascade.
module fa_32b (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);
    always_comb begin
        logic carry;
        carry = c_in;
        sum   = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end
endmodule

module fa_32b_sched #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_cin,
    output logic [NUM_REQ-1:0]      grant,
    output logic [IDX_W-1:0]        grant_idx,
    output logic [NUM_REQ-1:0]      done,
    output logic [31:0]             sum,
    output logic                    c_out,
    output logic                    busy
`ifdef FA_32B_SCHED_OVF_EN
    ,
    output logic                    ovf
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [31:0]          a_q, a_d;
    logic [31:0]          b_q, b_d;
    logic                 cin_q, cin_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [31:0]          sum_q, sum_d;
    logic                 c_out_q, c_out_d;
`ifdef FA_32B_SCHED_OVF_EN
    logic                 ovf_q, ovf_d;
`endif

    // Unpacked views of the packed operand buses.
    logic [31:0] a_arr [NUM_REQ];
    logic [31:0] b_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[32*gi +: 32];
            assign b_arr[gi] = req_b[32*gi +: 32];
        end
    endgenerate

    // The shared adder sees only the operand registers.
    logic [31:0] fa_sum;
    logic        fa_c_out;

    fa_32b u_fa (
        .a     (a_q),
        .b     (b_q),
        .c_in  (cin_q),
        .sum   (fa_sum),
        .c_out (fa_c_out)
    );

    // Round-robin winner: first active request at or above rr_q, wrapping.
    logic             found;
    logic [IDX_W-1:0] win_idx;

    always_comb begin
        logic [IDX_W:0] cand;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Pointer value following the current owner.
    logic [IDX_W:0] rr_inc;
    always_comb begin
        rr_inc = {1'b0, grant_idx_q} + (IDX_W+1)'(1);
        if (rr_inc >= NUM_REQ_W) begin
            rr_inc = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        done_d      = '0;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
`ifdef FA_32B_SCHED_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    a_d         = a_arr[win_idx];
                    b_d         = b_arr[win_idx];
                    cin_d       = req_cin[win_idx];
                    grant_d     = NUM_REQ'(1) << win_idx;
                    grant_idx_d = win_idx;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                sum_d   = fa_sum;
                c_out_d = fa_c_out;
`ifdef FA_32B_SCHED_OVF_EN
                ovf_d   = (a_q[31] == b_q[31]) && (fa_sum[31] != a_q[31]);
`endif
                // done is registered so it is high exactly during RESP.
                done_d  = grant_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rr_d    = rr_inc[IDX_W-1:0];
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            done_q      <= '0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
`ifdef FA_32B_SCHED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            done_q      <= done_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
`ifdef FA_32B_SCHED_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef FA_32B_SCHED_OVF_EN
    assign ovf       = ovf_q;
`endif

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));
    a_done_onehot:  assert property (@(posedge clk) disable iff (reset) $onehot0(done_q));
    a_done_single:  assert property (@(posedge clk) disable iff (reset) (|done_q) |=> !(|done_q));

endmodule
